// File: rtl/zbt_arbiter.sv
// Two-port round-robin arbiter for a pipelined ZBT SRAM: grants one access per
// cycle and returns read data / drives write data LAT cycles after the grant.
module zbt_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36,
    parameter int LAT    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_grant,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_grant,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

    port_t             last_grant;
    logic              grant_a;
    logic              grant_b;
    logic              granted;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    port_t             sel_port;
    logic [ADDR_W-1:0] addr_q;

    logic              rd_v    [LAT];
    port_t             rd_port [LAT];
    logic [DATA_W-1:0] wr_data [LAT];
    logic              tag_v;
    port_t             tag_port;
    logic [DATA_W-1:0] a_dout_q;
    logic [DATA_W-1:0] b_dout_q;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                grant_a = (last_grant == PORT_B);
                grant_b = (last_grant == PORT_A);
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
        granted  = grant_a || grant_b;
        sel_port = grant_b ? PORT_B : PORT_A;
        sel_we   = grant_b ? b_we   : a_we;
        sel_addr = grant_b ? b_addr : a_addr;
        sel_din  = grant_b ? b_din  : a_din;
    end

    // dout must be visible together with rvalid, so it captures mem_dout on the
    // edge where the read tag moves into the final pipeline stage.
    generate
        if (LAT == 1) begin : g_tag_direct
            assign tag_v    = granted && !sel_we;
            assign tag_port = sel_port;
        end else begin : g_tag_pipe
            assign tag_v    = rd_v[LAT-2];
            assign tag_port = rd_port[LAT-2];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= PORT_B;
            addr_q     <= '0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                rd_v[i]    <= 1'b0;
                rd_port[i] <= PORT_A;
                wr_data[i] <= '0;
            end
        end else begin
            if (granted) begin
                last_grant <= sel_port;
                addr_q     <= sel_addr;
            end
            rd_v[0]    <= granted && !sel_we;
            rd_port[0] <= sel_port;
            wr_data[0] <= (granted && sel_we) ? sel_din : '0;
            for (int unsigned i = 1; i < LAT; i++) begin
                rd_v[i]    <= rd_v[i-1];
                rd_port[i] <= rd_port[i-1];
                wr_data[i] <= wr_data[i-1];
            end
            if (tag_v && tag_port == PORT_A) a_dout_q <= mem_dout;
            if (tag_v && tag_port == PORT_B) b_dout_q <= mem_dout;
        end
    end

    assign a_grant  = grant_a;
    assign b_grant  = grant_b;
    assign a_rvalid = rd_v[LAT-1] && (rd_port[LAT-1] == PORT_A);
    assign b_rvalid = rd_v[LAT-1] && (rd_port[LAT-1] == PORT_B);
    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;
    assign mem_we   = granted && sel_we;
    assign mem_addr = granted ? sel_addr : addr_q;
    assign mem_din  = wr_data[LAT-1];

endmodule
